// File: rtl/bus_arbiter4_if.sv
// Request/grant/data bundle between four producers and the shared-bus arbiter.
// master: the producer side; slave: the arbiter.
interface bus_arbiter4_if #(
    parameter int size = 8
);
    logic [3:0]        req;
    logic [size*4-1:0] inputVal;
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic [size-1:0]   y;
    logic              valid;

    modport master (
        output req, inputVal,
        input  grant, sel, y, valid
    );

    modport slave (
        input  req, inputVal,
        output grant, sel, y, valid
    );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-source round-robin arbiter with bounded tenure that drives the select of
// a registered 4:1 word mux feeding one shared destination.
//
// state | meaning
// IDLE  | no owner, grant = 0, waiting for any request
// BUSY  | sel owns the bus; hold counts cycles of the current tenure
module bus_arbiter4 #(
    parameter int size    = 8,
    parameter int MAXHOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter4_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAXHOLD);

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [7:0]        hold_q, hold_d;
    logic [size-1:0]   y_q, y_d;
    logic              valid_q, valid_d;

    logic              win_found;
    logic [1:0]        win_idx;

    // Scan base+1, base+2, base+3, base; the nearest asserted request wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        {win_found, win_idx} = rr_pick(bus.req, last_q);

        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    hold_d  = 8'd1;
                    state_d = BUSY;
                end else begin
                    grant_d = 4'b0000;
                end
            end
            BUSY: begin
                if (bus.req[sel_q] && (hold_q < MAX_HOLD_C)) begin
                    hold_d = hold_q + 8'd1;
                end else if (win_found) begin
                    // Direct hand-over; a timed-out sole requester gets a fresh tenure.
                    grant_d = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    hold_d  = 8'd1;
                end else begin
                    grant_d = 4'b0000;
                    hold_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = 4'b0000;
                hold_d  = 8'd0;
                state_d = IDLE;
            end
        endcase

        y_d     = bus.inputVal[int'(sel_q)*size +: size];
        valid_d = (grant_q != 4'b0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.y     = y_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: one instance with MAXHOLD=16, one with MAXHOLD=2,
// both fed the same requests and source words.
module tb_bus_arbiter4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] inval;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter4_if #(.size(8)) if16 ();
    bus_arbiter4_if #(.size(8)) if2 ();

    assign if16.req      = req;
    assign if16.inputVal = inval;
    assign if2.req       = req;
    assign if2.inputVal  = inval;

    bus_arbiter4 #(.size(8), .MAXHOLD(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    bus_arbiter4 #(.size(8), .MAXHOLD(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        inval = {8'h44, 8'h33, 8'h22, 8'h11};
        #1 rst = 1'b1;
        #1;
        check_eq("rst_grant", 32'(if16.grant), 32'h0);
        check_eq("rst_sel",   32'(if16.sel),   32'h0);
        check_eq("rst_y",     32'(if16.y),     32'h0);
        check_eq("rst_valid", 32'(if16.valid), 32'h0);
        check_eq("rst_hold",  32'(dut16.hold_q), 32'h0);
        check_eq("rst_last",  32'(dut16.last_q), 32'h3);

        // Single request: grant after 1 edge, data after 2.
        @(posedge clk);
        #3 rst = 1'b0;
        req = 4'b0001;
        step();
        check_eq("t1_grant", 32'(if16.grant), 32'h1);
        check_eq("t1_sel",   32'(if16.sel),   32'h0);
        check_eq("t1_valid0", 32'(if16.valid), 32'h0);
        step();
        check_eq("t1_y",     32'(if16.y),     32'h11);
        check_eq("t1_valid1", 32'(if16.valid), 32'h1);

        // All requests drop from owner 0.
        req = 4'b0000;
        step();
        check_eq("t1_drop_grant", 32'(if16.grant), 32'h0);
        check_eq("t1_drop_valid", 32'(if16.valid), 32'h1);
        step();
        check_eq("t1_drop_valid2", 32'(if16.valid), 32'h0);
        check_eq("t1_drop_sel",    32'(if16.sel),   32'h0);

        // Rotation with MAXHOLD=2 and all four requesting.
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            step();
            check_eq("t2_grant", 32'(if2.grant), 32'(4'b0001 << (((k - 1) / 2) % 4)));
            if (k >= 2) begin
                check_eq("t2_y",     32'(if2.y),     32'(8'h11 * (((k - 2) / 2) % 4 + 1)));
                check_eq("t2_valid", 32'(if2.valid), 32'h1);
            end
        end

        // Owner 2 drops after 3 cycles with source 0 waiting.
        do_reset();
        req = 4'b0100;
        step();
        check_eq("t3_grant_a", 32'(if16.grant), 32'h4);
        req = 4'b0101;
        step();
        check_eq("t3_grant_b", 32'(if16.grant), 32'h4);
        check_eq("t3_valid_b", 32'(if16.valid), 32'h1);
        step();
        check_eq("t3_grant_c", 32'(if16.grant), 32'h4);
        check_eq("t3_last",    32'(dut16.last_q), 32'h2);
        req = 4'b0001;
        step();
        check_eq("t3_grant_d", 32'(if16.grant), 32'h1);
        check_eq("t3_sel_d",   32'(if16.sel),   32'h0);
        check_eq("t3_valid_d", 32'(if16.valid), 32'h1);
        check_eq("t3_y_d",     32'(if16.y),     32'h33);
        step();
        check_eq("t3_valid_e", 32'(if16.valid), 32'h1);
        check_eq("t3_y_e",     32'(if16.y),     32'h11);

        // Sole requester 3 for 40 cycles: continuous grant, tenure wraps 16 -> 1.
        do_reset();
        req = 4'b1000;
        for (int k = 1; k <= 40; k++) begin
            step();
            check_eq("t4_grant", 32'(if16.grant), 32'h8);
            check_eq("t4_hold",  32'(dut16.hold_q), 32'(((k - 1) % 16) + 1));
        end

        // Everyone drops: sel keeps the last owner.
        req = 4'b0000;
        step();
        check_eq("t5_grant", 32'(if16.grant), 32'h0);
        check_eq("t5_sel",   32'(if16.sel),   32'h3);
        check_eq("t5_valid", 32'(if16.valid), 32'h1);
        step();
        check_eq("t5_valid2", 32'(if16.valid), 32'h0);
        check_eq("t5_sel2",   32'(if16.sel),   32'h3);

        // Asynchronous reset in mid-tenure.
        req = 4'b0010;
        step();
        check_eq("t6_grant", 32'(if16.grant), 32'h2);
        step();
        check_eq("t6_y",     32'(if16.y),     32'h22);
        #3 rst = 1'b1;
        #1;
        check_eq("t6_rst_grant", 32'(if16.grant), 32'h0);
        check_eq("t6_rst_sel",   32'(if16.sel),   32'h0);
        check_eq("t6_rst_y",     32'(if16.y),     32'h0);
        check_eq("t6_rst_valid", 32'(if16.valid), 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        req = 4'b1010;
        step();
        check_eq("t6_post_grant", 32'(if16.grant), 32'h2);
        check_eq("t6_post_sel",   32'(if16.sel),   32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
